// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the two-requester RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'b00,
        OWN_PORT_A = 2'b01,
        OWN_PORT_B = 2'b10
    } owner_e;

    localparam int CNT_WIDTH = 16;

    function automatic owner_e state_owner(input arb_state_e s);
        return s == OWN_A ? OWN_PORT_A : s == OWN_B ? OWN_PORT_B : OWN_NONE;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction

endpackage

// File: rtl/ram_arb_rd_return.sv
// ram_arb_rd_return: tracks which requester issued each in-flight read and steers ram_q back to it.
module ram_arb_rd_return #(
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_a,
    input  logic                  issue_b,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] a_q,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic                  a_rvalid,
    output logic                  b_rvalid
);
    // One-hot owner tag per pipeline stage; both bits clear means no read in that slot.
    logic [RAM_LATENCY-1:0] tag_a, tag_b;
    logic [DATA_WIDTH-1:0]  a_hold, b_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_a  <= '0;
            tag_b  <= '0;
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            tag_a  <= (tag_a << 1) | RAM_LATENCY'(issue_a);
            tag_b  <= (tag_b << 1) | RAM_LATENCY'(issue_b);
            a_hold <= a_rvalid ? ram_q : a_hold;
            b_hold <= b_rvalid ? ram_q : b_hold;
        end
    end

    assign a_rvalid = tag_a[RAM_LATENCY-1];
    assign b_rvalid = tag_b[RAM_LATENCY-1];
    // ram_q is only valid in the return cycle, so it is passed straight through then and held after.
    assign a_q = a_rvalid ? ram_q : a_hold;
    assign b_q = b_rvalid ? ram_q : b_hold;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port RAM between requesters A and B with bounded bursts.
// Define RAM_ARB_PERF_CNT_EN to add saturating per-port grant and stall counters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] a_q,
    output logic                  a_rvalid,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic                  b_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [1:0]            owner
`ifdef RAM_ARB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  a_grant_cnt,
    output logic [CNT_WIDTH-1:0]  b_grant_cnt,
    output logic [CNT_WIDTH-1:0]  a_stall_cnt,
    output logic [CNT_WIDTH-1:0]  b_stall_cnt
`endif
);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e    state, state_nx;
    logic [BW-1:0] burst_cnt, burst_nx;
    logic          gnt_a, gnt_b, at_max, other_waiting;

    assign at_max = burst_cnt == BW'(MAX_BURST);

    // A wins from IDLE and keeps OWN_A until its allowance runs out; B only loses in OWN_B once exhausted.
    always_comb begin
        gnt_a         = !rst && a_valid && (!b_valid || (state == OWN_A ? !at_max : state == OWN_B ? at_max : 1'b1));
        gnt_b         = !rst && b_valid && !gnt_a;
        state_nx      = gnt_a ? OWN_A : gnt_b ? OWN_B : IDLE;
        other_waiting = gnt_a ? b_valid : a_valid;
        burst_nx      = state_nx == IDLE ? '0 :
                        state_nx != state ? BW'(1) :
                        (other_waiting && !at_max) ? burst_cnt + 1'b1 : burst_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign ram_en    = gnt_a || gnt_b;
    assign ram_we    = gnt_a ? a_we : gnt_b && b_we;
    assign ram_addr  = gnt_a ? a_addr : gnt_b ? b_addr : '0;
    assign ram_wdata = gnt_a ? a_data : gnt_b ? b_data : '0;
    assign owner     = state_owner(state);

    ram_arb_rd_return #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_LATENCY(RAM_LATENCY)
    ) u_rd_return (
        .clk     (clk),
        .rst     (rst),
        .issue_a (gnt_a && !a_we),
        .issue_b (gnt_b && !b_we),
        .ram_q   (ram_q),
        .a_q     (a_q),
        .b_q     (b_q),
        .a_rvalid(a_rvalid),
        .b_rvalid(b_rvalid)
    );

`ifdef RAM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
            a_stall_cnt <= '0;
            b_stall_cnt <= '0;
        end else begin
            a_grant_cnt <= sat_inc(a_grant_cnt, gnt_a);
            b_grant_cnt <= sat_inc(b_grant_cnt, gnt_b);
            a_stall_cnt <= sat_inc(a_stall_cnt, a_valid && !gnt_a);
            b_stall_cnt <= sat_inc(b_stall_cnt, b_valid && !gnt_b);
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random stimulus against a transaction-level model of the arbiter.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 3;
    localparam int MB  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, a_rvalid, b_rvalid;
    logic [DW-1:0] a_q, b_q;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_q;
    logic [1:0]    owner;
`ifdef RAM_ARB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] a_grant_cnt, b_grant_cnt, a_stall_cnt, b_stall_cnt;
`endif

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RAM_LATENCY(LAT),
        .MAX_BURST  (MB)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
        .a_q(a_q), .a_rvalid(a_rvalid),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .b_q(b_q), .b_rvalid(b_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_q(ram_q), .owner(owner)
`ifdef RAM_ARB_PERF_CNT_EN
        , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
        .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt)
`endif
    );

    // Environment RAM: write-first, read data appears LAT cycles after the access, junk otherwise.
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [LAT];
    assign ram_q = pipe[LAT-1];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : DW'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } ret_t;

    int            checks = 0, errors = 0;
    int            cyc = 0, last_g = 0;
    int            m_own = 0, m_streak = 0;
    int            m_agc = 0, m_bgc = 0, m_asc = 0, m_bsc = 0;
    logic [DW-1:0] m_aq = '0, m_bq = '0;
    logic [DW-1:0] ref_mem [256];
    ret_t          rq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Who gets the port: lone requester wins; on contention A wins a fresh arbitration,
    // otherwise the owner keeps it until it has used MB grants while the other waited.
    function automatic int model_grant(input logic av, input logic bv);
        if (!av && !bv) return 0;
        if (av != bv) return av ? 1 : 2;
        if (m_own == 0) return 1;
        return (m_streak < MB) ? m_own : 3 - m_own;
    endfunction

    task automatic model_reset();
        m_own = 0; m_streak = 0; rq.delete(); m_aq = '0; m_bq = '0;
        m_agc = 0; m_bgc = 0; m_asc = 0; m_bsc = 0; last_g = 0;
    endtask

    task automatic rst_check();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_q", a_q, 0);
        chk("rst_b_q", b_q, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_owner", owner, 0);
`ifdef RAM_ARB_PERF_CNT_EN
        chk("rst_a_grant_cnt", a_grant_cnt, 0);
        chk("rst_b_stall_cnt", b_stall_cnt, 0);
`endif
    endtask

    // Called right after a falling edge with inputs already applied; checks this cycle, advances the model.
    task automatic step();
        int            g;
        ret_t          r;
        logic          ea, eb, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        #1;
        g    = model_grant(a_valid, b_valid);
        we   = g == 1 ? a_we : g == 2 ? b_we : 1'b0;
        addr = g == 1 ? a_addr : g == 2 ? b_addr : '0;
        dat  = g == 1 ? a_data : g == 2 ? b_data : '0;
`ifdef RAM_ARB_PERF_CNT_EN
        chk("a_grant_cnt", a_grant_cnt, m_agc);
        chk("b_grant_cnt", b_grant_cnt, m_bgc);
        chk("a_stall_cnt", a_stall_cnt, m_asc);
        chk("b_stall_cnt", b_stall_cnt, m_bsc);
`endif
        chk("a_ready", a_ready, g == 1);
        chk("b_ready", b_ready, g == 2);
        chk("ram_en", ram_en, g != 0);
        chk("ram_we", ram_we, we);
        chk("ram_addr", ram_addr, addr);
        chk("ram_wdata", ram_wdata, dat);
        chk("owner", owner, m_own);
        ea = 1'b0;
        eb = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.port == 1) begin ea = 1'b1; m_aq = r.data; end
            else begin eb = 1'b1; m_bq = r.data; end
        end
        chk("a_rvalid", a_rvalid, ea);
        chk("b_rvalid", b_rvalid, eb);
        chk("a_q", a_q, m_aq);
        chk("b_q", b_q, m_bq);
        if (g != 0 && we) ref_mem[addr] = dat;
        else if (g != 0) rq.push_back('{cyc + LAT, g, ref_mem[addr]});
        if (g == 1) m_agc++; else if (a_valid) m_asc++;
        if (g == 2) m_bgc++; else if (b_valid) m_bsc++;
        if (g == 0) begin m_own = 0; m_streak = 0; end
        else if (g != m_own) begin m_own = g; m_streak = 1; end
        else if ((g == 1 ? b_valid : a_valid) && m_streak < MB) m_streak++;
        last_g = g;
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_valid = v; a_we = we; a_addr = ad; a_data = d;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_valid = v; b_we = we; b_addr = ad; b_data = d;
    endtask

    // New request only once the previous one was accepted (or none was pending).
    task automatic gen(input int pa, input int pb);
        if (!a_valid || last_g == 1)
            set_a($urandom_range(0, 99) < pa, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
        if (!b_valid || last_g == 2)
            set_b($urandom_range(0, 99) < pb, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        set_a(1, 1, 8'h33, 8'h44);
        set_b(1, 0, 8'h55, 8'h66);
        @(negedge clk);
        #1 rst_check();
        @(negedge clk);
        rst = 1'b0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        model_reset();
        @(negedge clk);

        // A write then read-back of the same address
        set_a(1, 1, 8'h10, 8'hA5); step();
        set_a(1, 0, 8'h10, 8'h00); step();
        set_a(0, 0, 0, 0);
        repeat (LAT) step();
        chk("a_q_readback", a_q, 8'hA5);

        // Simultaneous first requests from IDLE
        set_a(1, 0, 8'h20, 0);
        set_b(1, 0, 8'h21, 0);
        step();
        set_a(0, 0, 0, 0);
        step();
        set_b(0, 0, 0, 0);
        repeat (LAT + 1) step();

        // Alternating reads with distinct data per port
        set_a(1, 1, 8'h01, 8'h11); step();
        set_a(0, 0, 0, 0);
        set_b(1, 1, 8'h02, 8'h22); step();
        for (int i = 0; i < 3; i++) begin
            set_b(0, 0, 0, 0);
            set_a(1, 0, 8'h01, 0); step();
            set_a(0, 0, 0, 0);
            set_b(1, 0, 8'h02, 0); step();
        end
        set_b(0, 0, 0, 0);
        repeat (LAT + 1) step();
        chk("a_q_interleave", a_q, 8'h11);
        chk("b_q_interleave", b_q, 8'h22);

        // Reset one cycle after a read grant drops the read
        set_a(1, 0, 8'h10, 0); step();
        rst = 1'b1;
        set_a(1, 0, 8'h30, 0);
        set_b(1, 1, 8'h31, 8'h77);
        #1 rst_check();
        @(negedge clk);
        rst = 1'b0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        model_reset();
        repeat (LAT) step();
        set_a(1, 1, 8'h05, 8'h5E);
        set_b(1, 1, 8'h06, 8'h6E);
        step();
        chk("post_rst_first_grant", last_g, 1);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        step();
        step();

        // Both requesters saturated: MB grants each, alternating
        k = 0;
        repeat (24) begin
            gen(100, 100);
            step();
            chk("burst_seq", last_g, ((k / MB) % 2 == 0) ? 1 : 2);
            k++;
        end

        for (int i = 0; i < 600; i++) begin
            gen(i < 300 ? 70 : 35, i < 300 ? 60 : 90);
            step();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        repeat (LAT + 1) step();
        chk("drain_empty", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM port between two requesters, A and B, each with its own valid/ready handshake.
- Performs round-robin arbitration with a bounded burst allowance and issues at most one RAM access per cycle.
- Routes read data back to the requester that issued the read, with a fixed latency.
- Sits between the port agents/masters and the RAM macro.

Parameters:
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 8, RAM data width
- RAM_LATENCY, 1, cycles from ram_en (read) to valid ram_q; legal range 1..4
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  requester A has a request
- a_ready  out  1  A request accepted this cycle (combinational grant)
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  A address
- a_data  in  DATA_WIDTH  A write data
- a_q  out  DATA_WIDTH  A read data
- a_rvalid  out  1  a_q valid, one-cycle pulse
- b_valid, b_ready, b_we, b_addr, b_data, b_q, b_rvalid: same as A, for requester B
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_q  in  DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after a read ram_en
- owner  out  2  registered current owner: 00 = none, 01 = A, 10 = B

Behaviour:
- Reset values: a_ready = b_ready = 0; a_rvalid = b_rvalid = 0; a_q = b_q = 0; ram_en = ram_we = 0; ram_addr = ram_wdata = 0; owner = 00; state IDLE; burst_cnt = 0; return pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced for them.
- The RAM control outputs ram_en, ram_we, ram_addr and ram_wdata are combinational from the granted requester. All of them are forced to 0 while rst is high.
- Handshake:
  - A transfer occurs when x_valid && x_ready.
  - At most one of a_ready and b_ready is high in any cycle.
  - x_ready is never high unless x_valid is high.
  - A requester holds its valid and payload stable until ready is seen.
- FSM states: IDLE, OWN_A, OWN_B. The state is registered; grant selection is combinational from the state, burst_cnt and the valids.
  - IDLE:
    - only a_valid -> grant A, next OWN_A
    - only b_valid -> grant B, next OWN_B
    - both valid -> grant A, next OWN_A (A wins ties from IDLE)
  - OWN_A:
    - a_valid and (!b_valid or burst_cnt < MAX_BURST) -> grant A, stay
    - b_valid and (!a_valid or burst_cnt == MAX_BURST) -> grant B, next OWN_B
    - neither valid -> no grant, next IDLE
  - OWN_B: symmetric to OWN_A.
- burst_cnt:
  - Set to 1 on the first grant to a new owner.
  - Incremented on each further grant to the same owner, but only while the other requester's valid is high; saturates at MAX_BURST.
  - Holds its value while the other requester is idle.
  - Cleared to 0 in IDLE.
- Writes: 0 latency through the block; ram_en = ram_we = 1 in the grant cycle; no rvalid.
- Reads:
  - ram_en = 1, ram_we = 0 in the grant cycle.
  - An owner-tag shift register of depth RAM_LATENCY tracks each read.
  - The owner's x_rvalid pulses exactly RAM_LATENCY cycles after the grant cycle, with x_q = ram_q captured in that cycle.
  - x_q holds its value between pulses.
- Back-to-back reads from alternating requesters each get their own return in issue order; no return is ever routed to the wrong port.
- Read-after-write to the same address in consecutive cycles: ordering is preserved by the single RAM port; the read observes the new data (RAM is write-first per access, no bypass in this block).
- owner reflects the registered state: IDLE = 00, OWN_A = 01, OWN_B = 10.

Optional Feature:
- Macro: RAM_ARB_PERF_CNT_EN.
- Defined:
  - Adds output ports a_grant_cnt, b_grant_cnt, a_stall_cnt, b_stall_cnt, each 16 bits, saturating, cleared on rst.
  - grant_cnt increments on each transfer.
  - stall_cnt increments on each cycle with x_valid && !x_ready.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_e {IDLE, OWN_A, OWN_B}
  - typedef enum logic [1:0] owner_e {OWN_NONE = 2'b00, OWN_PORT_A = 2'b01, OWN_PORT_B = 2'b10}
  - localparam CNT_WIDTH = 16
- One natural sub-module, ram_arb_rd_return: the RAM_LATENCY-deep owner-tag/valid shift register plus the q/rvalid demux. The FSM and grant logic stay in the top module.

Test Plan:
- Single A write then read: A writes addr 0x10 data 0xA5, then reads 0x10 -> a_ready high in the same cycle each time; a_rvalid pulses 1 cycle after the read grant (RAM_LATENCY = 1) with a_q = 0xA5; b_rvalid stays 0.
- Simultaneous first request from IDLE: a_valid and b_valid high together -> A granted first; owner = 01 on the next cycle; b_ready = 0 in that cycle.
- Burst limit, MAX_BURST = 4: A and B both continuously valid -> grant pattern A,A,A,A,B,B,B,B,A,...; never more than 4 consecutive same-port grants.
- Interleaved reads with RAM_LATENCY = 3: A reads 0x01 (holds 0x11), B reads 0x02 (holds 0x22), alternating -> a_q = 0x11 and b_q = 0x22, each exactly 3 cycles after its own grant, in issue order.
- Reset mid-read: assert rst one cycle after a read grant -> no rvalid on either port; all outputs 0 while rst is high; first grant after release follows the IDLE rules.
- RAM_ARB_PERF_CNT_EN: B held valid for 3 cycles while A owns the port -> b_stall_cnt = 3; a_grant_cnt equals the number of A transfers.
